// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and defaults for the UART transmit path
package uart_pkg;
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DONE = 2'd2
    } feeder_state_e;

    localparam int UART_FIFO_DEPTH  = 16;
    localparam int UART_ACK_TIMEOUT = 64;
endpackage

// File: rtl/uart_tx_feeder_if.sv
// rtl/uart_tx_feeder_if.sv - producer and transmitter handshakes of the feeder
interface uart_tx_feeder_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;

    modport master (
        output in_data, in_valid, tx_busy,
        input  in_ready, tx_data, tx_start
    );

    modport slave (
        input  in_data, in_valid, tx_busy,
        output in_ready, tx_data, tx_start
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock byte FIFO with synchronous flush
module uart_sync_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [7:0]             wdata,
    input  logic                   pop,
    output logic [7:0]             rdata,
    input  logic                   flush,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push_ok, pop_ok;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // flush discards everything, including a same-cycle pop's pointer advance
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - buffers producer bytes and hands them to the UART transmitter
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH       = UART_FIFO_DEPTH,
    parameter int ACK_TIMEOUT = UART_ACK_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_tx_feeder_if.slave        bus,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] level,
    output logic                   timeout_err
);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    feeder_state_e state_q, state_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_start_q, tx_start_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_err_q, timeout_err_d;
    logic          push, pop, full, empty;
    logic [7:0]    head;

    assign bus.in_ready = rst_n && !full && !flush;
    assign push         = bus.in_valid && bus.in_ready;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = tx_start_q;
    assign timeout_err  = timeout_err_q;

    uart_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (bus.in_data),
        .pop   (pop),
        .rdata (head),
        .flush (flush),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_comb begin
        state_d       = state_q;
        tx_data_d     = tx_data_q;
        tx_start_d    = 1'b0;
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
        pop           = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !bus.tx_busy) begin
                    pop        = 1'b1;
                    tx_data_d  = head;
                    tx_start_d = 1'b1;
                    cnt_d      = CW'(ACK_TIMEOUT);
                    state_d    = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // a transmitter that never acknowledges loses the byte; no retry
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == '0) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            tx_data_q     <= 8'h00;
            tx_start_q    <= 1'b0;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            tx_start_q    <= tx_start_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
endmodule
